// File: rtl/block_loader_pkg.sv
// Shared definitions for the code-block loader: block sizes, byte counts
// and the loader state encoding.
package block_loader_pkg;

   localparam int K_SMALL = 1056;
   localparam int K_LARGE = 6144;

   localparam logic [9:0] NBYTES_SMALL = 10'd132;
   localparam logic [9:0] NBYTES_LARGE = 10'd768;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_FILL = 2'b01,
      ST_FULL = 2'b10
   } loader_state_t;

   // Number of bytes that make up a block of the given size selector.
   function automatic logic [9:0] nbytes_for(input logic k6144);
      logic [9:0] n;
      if (k6144) begin
         n = NBYTES_LARGE;
      end else begin
         n = NBYTES_SMALL;
      end
      return n;
   endfunction

endpackage

// File: rtl/block_loader_byte_lane_decoder.sv
// Turns the current byte count and the accept strobe into a one-hot
// per-byte write enable for the parallel block register.
module byte_lane_decoder
   import block_loader_pkg::*;
#(
   parameter int NLANES = 768,
   parameter int LW     = 10
) (
   input  logic [LW-1:0]     lane,
   input  logic              accept,
   output logic [NLANES-1:0] lane_en
);

   // One-hot decode of the lane index, gated by the accept strobe.
   always_comb begin
      lane_en = '0;
      for (int i = 0; i < NLANES; i++) begin
         if (accept && (lane == i[LW-1:0])) begin
            lane_en[i] = 1'b1;
         end else begin
            lane_en[i] = 1'b0;
         end
      end
   end

endmodule

// File: rtl/block_loader.sv
// Flow-controlled code-block loader: assembles 1056- or 6144-bit blocks
// from a byte stream and presents them until the consumer acknowledges.
module block_loader
   import block_loader_pkg::*;
#(
   parameter int KMAX = 6144,
   parameter int KMIN = 1056
) (
   input  logic            clock,
   input  logic            reset_n,
   input  logic            k_size_6144,
   input  logic [7:0]      databyte_in,
   input  logic            in_valid,
   output logic            in_ready,
   output logic [KMAX-1:0] block,
   output logic            block_k6144,
   output logic            block_valid,
   input  logic            block_ack,
   output logic [9:0]      byte_cnt
);

   localparam int         NLANES  = KMAX / 8;
   localparam logic [9:0] N_SMALL = 10'(KMIN / 8);
   localparam logic [9:0] N_LARGE = 10'(KMAX / 8);

   loader_state_t     state_r;
   logic [9:0]        cnt_r;
   logic              k_r;
   logic              in_ready_r;
   logic              valid_r;
   logic [KMAX-1:0]   block_r;

   logic              accept_s;
   logic              first_accept_s;
   logic              fill_accept_s;
   logic [9:0]        cnt_next_s;
   logic [9:0]        n_last_s;
   logic [NLANES-1:0] lane_en_s;

   // Accept strobes and the byte count that ends the current block.
   always_comb begin
      accept_s       = in_valid && in_ready_r;
      first_accept_s = accept_s && (state_r == ST_IDLE);
      fill_accept_s  = accept_s && (state_r == ST_FILL);
      cnt_next_s     = cnt_r + 10'd1;
      if (k_r) begin
         n_last_s = N_LARGE;
      end else begin
         n_last_s = N_SMALL;
      end
   end

   byte_lane_decoder #(
      .NLANES (NLANES),
      .LW     (10)
   ) u_lane_dec (
      .lane    (cnt_r),
      .accept  (fill_accept_s),
      .lane_en (lane_en_s)
   );

   // Loader FSM with byte counter, size latch and registered handshake flags.
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state_r    <= ST_IDLE;
         cnt_r      <= 10'd0;
         k_r        <= 1'b0;
         in_ready_r <= 1'b1;
         valid_r    <= 1'b0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (in_valid) begin
                  k_r     <= k_size_6144;
                  cnt_r   <= 10'd1;
                  state_r <= ST_FILL;
               end
            end
            ST_FILL: begin
               if (in_valid) begin
                  cnt_r <= cnt_next_s;
                  if (cnt_next_s == n_last_s) begin
                     state_r    <= ST_FULL;
                     in_ready_r <= 1'b0;
                     valid_r    <= 1'b1;
                  end
               end
            end
            ST_FULL: begin
               // Ack is only honoured here; elsewhere it is ignored.
               if (block_ack) begin
                  state_r    <= ST_IDLE;
                  cnt_r      <= 10'd0;
                  in_ready_r <= 1'b1;
                  valid_r    <= 1'b0;
               end
            end
            default: begin
               state_r    <= ST_IDLE;
               cnt_r      <= 10'd0;
               k_r        <= 1'b0;
               in_ready_r <= 1'b1;
               valid_r    <= 1'b0;
            end
         endcase
      end
   end

   // Block register: first byte clears the upper bits, later bytes land in
   // their decoded lane; contents hold through FULL and after the ack.
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         block_r <= '0;
      end else if (first_accept_s) begin
         block_r <= {{(KMAX-8){1'b0}}, databyte_in};
      end else begin
         for (int i = 0; i < NLANES; i++) begin
            if (lane_en_s[i]) begin
               block_r[8*i +: 8] <= databyte_in;
            end
         end
      end
   end

   assign in_ready    = in_ready_r;
   assign block_valid = valid_r;
   assign block       = block_r;
   assign block_k6144 = k_r;
   assign byte_cnt    = cnt_r;

endmodule

// File: tb/tb_block_loader.sv
// Randomized self-checking bench for block_loader with a byte-level
// behavioural model compared against the DUT on every cycle.
module tb_block_loader;

   logic          clock;
   logic          reset_n;
   logic          k_size_6144;
   logic [7:0]    databyte_in;
   logic          in_valid;
   logic          in_ready;
   logic [6143:0] block;
   logic          block_k6144;
   logic          block_valid;
   logic          block_ack;
   logic [9:0]    byte_cnt;

   block_loader #(.KMAX(6144), .KMIN(1056)) dut (
      .clock       (clock),
      .reset_n     (reset_n),
      .k_size_6144 (k_size_6144),
      .databyte_in (databyte_in),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .block       (block),
      .block_k6144 (block_k6144),
      .block_valid (block_valid),
      .block_ack   (block_ack),
      .byte_cnt    (byte_cnt)
   );

   int n_cmp  = 0;
   int n_fail = 0;
   bit checking = 0;

   // Behavioural model: bytes received so far, latched size, full flag.
   logic [6143:0] m_block;
   int            m_cnt;
   bit            m_full;
   bit            m_k;

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic chk_block(input string nm, input logic [6143:0] act, input logic [6143:0] exp);
      int first_bad;
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         first_bad = -1;
         for (int i = 0; i < 768; i++) begin
            if (first_bad < 0 && act[8*i +: 8] !== exp[8*i +: 8]) first_bad = i;
         end
         $display("FAIL %s: byte %0d got %0h expected %0h at %0t", nm, first_bad,
                  act[8*first_bad +: 8], exp[8*first_bad +: 8], $time);
      end
   endtask

   task automatic model_step();
      int n;
      if (!reset_n) begin
         m_block = '0; m_cnt = 0; m_full = 0; m_k = 0;
      end else if (m_full) begin
         if (block_ack) begin
            m_full = 0;
            m_cnt  = 0;
         end
      end else if (in_valid) begin
         if (m_cnt == 0) begin
            m_k     = k_size_6144;
            m_block = '0;
         end
         m_block[8*m_cnt +: 8] = databyte_in;
         m_cnt++;
         n = m_k ? 6144/8 : 1056/8;
         if (m_cnt == n) m_full = 1;
      end
   endtask

   // Advance the model on each rising edge with the inputs seen there.
   initial begin
      forever begin
         @(posedge clock);
         model_step();
      end
   end

   // Compare every DUT output against the model on each falling edge.
   initial begin
      forever begin
         @(negedge clock);
         if (checking) begin
            chk("in_ready", 64'(in_ready), 64'(!m_full));
            chk("block_valid", 64'(block_valid), 64'(m_full));
            chk("byte_cnt", 64'(byte_cnt), 64'(m_cnt));
            chk("block_k6144", 64'(block_k6144), 64'(m_k));
            chk_block("block", block, m_block);
         end
      end
   end

   // Offer one byte (after optional random gaps) until it is accepted.
   task automatic send_byte(input logic [7:0] b, input int gap_pct);
      int guard = 0;
      while ($urandom_range(99) < gap_pct) begin
         in_valid = 1'b0;
         @(negedge clock);
      end
      in_valid    = 1'b1;
      databyte_in = b;
      while (!in_ready) begin
         guard++;
         if (guard > 200) begin
            n_cmp++; n_fail++;
            $display("FAIL send_timeout: in_ready stuck %0b expected 1", in_ready);
            break;
         end
         @(negedge clock);
      end
      @(negedge clock);
      in_valid = 1'b0;
   endtask

   task automatic ack_block();
      int guard = 0;
      while (!block_valid && guard < 50) begin
         guard++;
         @(negedge clock);
      end
      chk("ack_wait_valid", 64'(block_valid), 64'd1);
      block_ack = 1'b1;
      @(negedge clock);
      block_ack = 1'b0;
   endtask

   initial begin
      logic [7:0] tmp_b;
      reset_n = 1'b0; k_size_6144 = 1'b0; databyte_in = 8'h00;
      in_valid = 1'b0; block_ack = 1'b0;

      // Reset held for two cycles.
      @(negedge clock);
      checking = 1;
      @(negedge clock);
      reset_n = 1'b1;
      chk("rst_in_ready", 64'(in_ready), 64'd1);
      chk("rst_valid", 64'(block_valid), 64'd0);
      chk("rst_cnt", 64'(byte_cnt), 64'd0);
      chk("rst_block_low", block[63:0], 64'd0);

      // Small block, back-to-back, with a spurious ack at byte 10.
      k_size_6144 = 1'b0;
      for (int i = 0; i < 132; i++) begin
         block_ack = (i == 10);
         send_byte(8'(i), 0);
         if (i == 10) begin
            block_ack = 1'b0;
            chk("spurious_ack_cnt", 64'(byte_cnt), 64'd11);
         end
      end
      chk("small_valid", 64'(block_valid), 64'd1);
      chk("small_b0", 64'(block[7:0]), 64'h00);
      chk("small_b1", 64'(block[15:8]), 64'h01);
      chk("small_b131", 64'(block[1055:1048]), 64'd131);
      chk("small_upper_zero", 64'(|block[6143:1056]), 64'd0);
      chk("small_cnt", 64'(byte_cnt), 64'd132);
      ack_block();
      chk("after_ack_valid", 64'(block_valid), 64'd0);

      // Large block with random gaps and k toggling after the first byte.
      k_size_6144 = 1'b1;
      for (int i = 0; i < 768; i++) begin
         send_byte(8'hA5, 30);
         k_size_6144 = 1'($urandom_range(1));
      end
      chk("large_valid", 64'(block_valid), 64'd1);
      chk("large_k", 64'(block_k6144), 64'd1);
      chk("large_b0", 64'(block[7:0]), 64'hA5);
      chk("large_b767", 64'(block[6143:6136]), 64'hA5);
      chk("large_cnt", 64'(byte_cnt), 64'd768);

      // Backpressure: hold a byte against a full loader for 20 cycles.
      k_size_6144 = 1'b0;
      in_valid = 1'b1; databyte_in = 8'h3C;
      repeat (20) @(negedge clock);
      chk("bp_ready", 64'(in_ready), 64'd0);
      chk("bp_block", 64'(block[15:0]), 64'hA5A5);
      block_ack = 1'b1;
      @(negedge clock);
      block_ack = 1'b0;
      chk("bp_valid_drop", 64'(block_valid), 64'd0);
      chk("bp_cnt_zero", 64'(byte_cnt), 64'd0);
      @(negedge clock);
      in_valid = 1'b0;
      chk("bp_first_cnt", 64'(byte_cnt), 64'd1);
      chk("bp_first_byte", 64'(block[15:0]), 64'h003C);
      for (int i = 1; i < 132; i++) begin
         tmp_b = 8'($urandom_range(255));
         send_byte(tmp_b, 20);
      end
      ack_block();

      // Reset in the middle of a fill, then a clean random small block.
      for (int i = 0; i < 50; i++) send_byte(8'($urandom_range(255)), 10);
      reset_n = 1'b0;
      @(negedge clock);
      reset_n = 1'b1;
      chk("midrst_cnt", 64'(byte_cnt), 64'd0);
      chk("midrst_block", 64'(|block), 64'd0);
      chk("midrst_ready", 64'(in_ready), 64'd1);
      for (int i = 0; i < 132; i++) begin
         k_size_6144 = (i == 0) ? 1'b0 : 1'($urandom_range(1));
         send_byte(8'($urandom_range(255)), 25);
      end
      chk("final_valid", 64'(block_valid), 64'd1);
      chk("final_k", 64'(block_k6144), 64'd0);
      ack_block();
      repeat (3) @(negedge clock);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
